vga_fetch: RTL
==============

VGA_FETCH -- requirements
Module: vga_fetch

Interface
REQ-001 Parameter HDISP, default 800: active pixels per line.
REQ-002 Parameter VDISP, default 480: active lines per frame.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000: byte address of framebuffer pixel (0,0).
REQ-004 wshb_clk  input  1  sole clock; all logic on rising edge.
REQ-005 wshb_rst  input  1  synchronous, active-high reset.
REQ-006 wshb_ifm  wshb_if.master  -  Wishbone master; uses cyc, stb, we, sel, adr[31:0], dat_sm[31:0], ack.
REQ-007 restart  input  1  single-cycle pulse: restart fetch at pixel (0,0), already synchronous to wshb_clk.
REQ-008 fifo_walmost_full  input  1  downstream pixel FIFO cannot accept more than 2 further words.
REQ-009 fifo_write  output  1  write strobe to pixel FIFO.
REQ-010 fifo_wdata  output  32  pixel word {8'h00, R, G, B} to pixel FIFO.
REQ-011 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.

Function
REQ-012 Pixel index idx counts 0..HDISP*VDISP-1, width $clog2(HDISP*VDISP); wraps to 0 after last pixel.
REQ-013 adr = BASE_ADDR + 4*idx, 32-bit unsigned, no carry out.
REQ-014 we = 0 and sel = 4'hF at all times.
REQ-015 FSM states: IDLE, READ, DRAIN.
REQ-016 IDLE -> READ when fifo_walmost_full = 0 and restart = 0; cyc and stb go high on the following cycle.
REQ-017 In READ, cyc = stb = 1 and adr stays stable until ack.
REQ-018 On ack in READ: capture dat_sm, increment idx (with wrap); stay in READ if fifo_walmost_full = 0, else go to IDLE with cyc and stb low on the next cycle.
REQ-019 fifo_write is high exactly one cycle after each accepted ack; fifo_wdata holds the captured word in that cycle. Latency is 1 cycle.
REQ-020 At most one outstanding request; never more than one fifo_write per ack.
REQ-021 frame_done is high in the same cycle as the fifo_write for idx = HDISP*VDISP-1.
REQ-022 restart in IDLE: idx <- 0; remain in IDLE that cycle.
REQ-023 restart in READ with no ack that cycle: go to DRAIN; cyc and stb stay high until ack; the data is discarded (no fifo_write); then idx <- 0 and go to IDLE.
REQ-024 restart in READ with ack in the same cycle: data is discarded; idx <- 0; go to IDLE. This holds for the last pixel too, with no frame_done.
REQ-025 restart in DRAIN: ignored.
REQ-026 fifo_walmost_full rising while in READ with no ack: the current request completes normally; stop after it.
REQ-027 Wishbone error and retry inputs are not used; a bus that never acks holds the FSM in READ or DRAIN.

Reset
REQ-028 wshb_rst forces state IDLE, idx 0, cyc 0, stb 0, fifo_write 0, fifo_wdata 0 and frame_done 0 on the next edge.
REQ-029 Reset mid-transaction drops cyc and stb immediately, no data is written, and fetch restarts at idx 0.
REQ-030 The first request after reset appears no earlier than 2 cycles after wshb_rst deasserts.

Structure
REQ-031 The FSM state enum and the pixel-word layout constants (RGB field offsets) belong in the shared video package alongside the display timing constants.
REQ-032 Flat module, no sub-modules; the dual-clock pixel FIFO sits outside, between this block and the display controller.

Verification
REQ-033 HDISP=4, VDISP=2, Wishbone slave acking 1 cycle after stb returning data = adr -> fifo_wdata sequence 0,4,...,28,0,4; frame_done once per 8 writes.
REQ-034 Hold fifo_walmost_full=1 from reset -> cyc never asserts; release it -> first adr = BASE_ADDR, first fifo_write 1 cycle after ack.
REQ-035 Assert fifo_walmost_full during the wait for ack on idx 3 -> exactly one more write (adr 12), then cyc low; release it -> resume at adr 16.
REQ-036 restart with stb high and ack delayed 5 cycles -> cyc held until ack, no fifo_write, next adr = BASE_ADDR.
REQ-037 restart coincident with ack of idx 7 -> no fifo_write, no frame_done, next adr = BASE_ADDR.
REQ-038 wshb_rst for 1 cycle mid-burst -> cyc and stb low on the next edge, no spurious fifo_write, fetch restarts at adr 0.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// Shared video package: display timing constants, the fetch FSM state encoding and the
// layout of a pixel word as written to the pixel FIFO ({8'h00, R, G, B}).
package vga_fetch_pkg;

  // Active area and blanking for the 800x480 panel.
  localparam int unsigned HDisp  = 800;
  localparam int unsigned HFp    = 40;
  localparam int unsigned HSync  = 48;
  localparam int unsigned HBp    = 40;
  localparam int unsigned VDisp  = 480;
  localparam int unsigned VFp    = 13;
  localparam int unsigned VSync  = 3;
  localparam int unsigned VBp    = 29;

  // Pixel word field offsets; the top byte is padding and always zero in memory.
  localparam int unsigned PixBOfs   = 0;
  localparam int unsigned PixGOfs   = 8;
  localparam int unsigned PixROfs   = 16;
  localparam int unsigned PixPadOfs = 24;
  localparam int unsigned PixFieldW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle (32-bit data, byte address).
//   master modport: drives cyc/stb/we/sel/adr/dat_ms, receives dat_sm/ack.
//   slave modport : the mirror image.
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_ms,
    input  dat_sm, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_ms,
    output dat_sm, ack
  );
endinterface

// File: rtl/vga_fetch.sv
// Framebuffer fetch engine: reads pixels sequentially over Wishbone (one outstanding read)
// and pushes each returned word into the downstream pixel FIFO.
// Ports:
//   wshb_clk, wshb_rst   - clock, synchronous active-high reset
//   wshb_ifm             - Wishbone master (read-only)
//   restart              - one-cycle pulse: restart fetch at pixel (0,0)
//   fifo_walmost_full    - FIFO can take at most 2 more words; stop issuing reads
//   fifo_write/_wdata    - FIFO write strobe and pixel word, one cycle after each ack
//   frame_done           - pulses with the FIFO write of the last pixel of a frame
module vga_fetch
  import vga_fetch_pkg::*;
#(
  parameter int unsigned HDISP     = HDisp,
  parameter int unsigned VDISP     = VDisp,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst,
  wshb_if.master      wshb_ifm,
  input  logic        restart,
  input  logic        fifo_walmost_full,
  output logic        fifo_write,
  output logic [31:0] fifo_wdata,
  output logic        frame_done
);

  localparam int unsigned    NPix    = HDISP * VDISP;
  localparam int unsigned    IdxW    = (NPix > 1) ? $clog2(NPix) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NPix - 1);

  fetch_state_e    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, idx_inc;
  logic            init_q;
  logic            wr_q, wr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            bus_active;

  assign idx_inc = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // init_q holds off the first request for one extra cycle after reset.
        if (restart) begin
          idx_d = '0;
        end else if (init_q && !fifo_walmost_full) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (wshb_ifm.ack) begin
          if (restart) begin
            // Data of the aborted request is dropped, including the last pixel.
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            wr_d    = 1'b1;
            wdata_d = wshb_ifm.dat_sm;
            done_d  = (idx_q == IdxLast);
            idx_d   = idx_inc;
            if (fifo_walmost_full) begin
              state_d = StIdle;
            end
          end
        end else if (restart) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Keep the cycle open until the slave answers, then discard the data.
        if (wshb_ifm.ack) begin
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wshb_clk) begin
    if (wshb_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      init_q  <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      init_q  <= 1'b1;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bus_active      = (state_q != StIdle);
  assign wshb_ifm.cyc    = bus_active;
  assign wshb_ifm.stb    = bus_active;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.adr    = BASE_ADDR + (32'(idx_q) << 2);
  assign wshb_ifm.dat_ms = '0;

  assign fifo_write = wr_q;
  assign fifo_wdata = wdata_q;
  assign frame_done = done_q;

endmodule
